// File: rtl/arb_pkg.sv
// Shared arbitration types and sizes for the N-way arbiters in this slice.
package arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SRC_W   = 2;

   typedef logic [SRC_W-1:0] src_idx_t;
endpackage

// File: rtl/mux4.sv
// Plain 4:1 payload mux; s picks d0..d3.
module mux4 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [1:0]       s,
   output logic [WIDTH-1:0] y
);
   always_comb begin
      unique case (s)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end
endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req_valid bit scanning from ptr upward, mod 4.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_valid,
   input  src_idx_t           ptr,
   output src_idx_t           winner,
   output logic               any_req
);
   src_idx_t idx;

   // Scan farthest-first so the candidate closest to ptr is written last and wins.
   always_comb begin
      winner = ptr;
      idx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ptr + src_idx_t'(k);
         if (req_valid[idx]) winner = idx;
      end
   end

   assign any_req = |req_valid;
endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter feeding a one-entry registered valid/ready output.
module rr_arb4
   import arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req_valid,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   input  logic [WIDTH-1:0] req_data2,
   input  logic [WIDTH-1:0] req_data3,
   output logic [3:0]       req_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src,
   input  logic             out_ready
);
   src_idx_t         ptr;
   src_idx_t         winner;
   logic             any_req;
   logic             load;
   logic             grant;
   logic [WIDTH-1:0] sel_data;

   rr_pick4 u_pick (
      .req_valid (req_valid),
      .ptr       (ptr),
      .winner    (winner),
      .any_req   (any_req)
   );

   mux4 #(.WIDTH(WIDTH)) u_mux (
      .d0 (req_data0),
      .d1 (req_data1),
      .d2 (req_data2),
      .d3 (req_data3),
      .s  (winner),
      .y  (sel_data)
   );

   // The register can take a new entry when empty or when its entry leaves this cycle.
   assign load  = ~rst & (~out_valid | out_ready);
   assign grant = load & any_req;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (grant) begin
         ptr       <= winner + src_idx_t'(1);
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_src   <= winner;
      end else if (out_valid & out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rr_arb4.sv
// Directed scoreboard bench for rr_arb4: stimulus queues expected outputs, a monitor pops on handshake.
module tb_rr_arb4;
   localparam int WIDTH = 32;

   typedef struct packed {
      logic [1:0]       src;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req_valid;
   logic [WIDTH-1:0] d [4];
   logic [3:0]       req_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_src;
   logic             out_ready;

   exp_t exp_q [$];
   int   checks   = 0;
   int   failures = 0;
   int   seq      = 0;
   logic [WIDTH-1:0] held;

   always #5 clk = ~clk;

   rr_arb4 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data0 (d[0]),
      .req_data1 (d[1]),
      .req_data2 (d[2]),
      .req_data3 (d[3]),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] idx_of(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   // One clock: drive inputs, check grant mid-cycle, queue the expected output at the edge.
   task automatic cyc(input logic r, input logic [3:0] rv, input logic ordy, input logic [3:0] exp_rr);
      exp_t e;
      logic [1:0] w;
      rst       = r;
      req_valid = rv;
      out_ready = ordy;
      @(negedge clk);
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rr});
      @(posedge clk);
      if (exp_rr != 4'd0) begin
         w      = idx_of(exp_rr);
         e.src  = w;
         e.data = d[w];
         held   = d[w];
         exp_q.push_back(e);
         #1;
         seq++;
         d[w] = {8'hD0, 6'd0, w, 16'(seq)};
      end else begin
         #1;
      end
   endtask

   // Monitor: every accepted output must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output src=%0d data=%h expected=none", out_src, out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_src !== e.src || out_data !== e.data) begin
               failures++;
               $display("FAIL output actual src=%0d data=%h expected src=%0d data=%h",
                        out_src, out_data, e.src, e.data);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) d[i] = {8'hD0, 6'd0, 2'(i), 16'hFFF0};
      rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b0;

      // Reset held two cycles with all requesters asking
      cyc(1'b1, 4'b1111, 1'b1, 4'b0000);
      cyc(1'b1, 4'b1111, 1'b1, 4'b0000);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_src",   {30'd0, out_src},   32'd0);
      chk("rst_out_data",  out_data,           32'd0);

      // Full contention: 0,1,2,3,0,1,2,3
      for (int k = 0; k < 8; k++)
         cyc(1'b0, 4'b1111, 1'b1, 4'b0001 << (k % 4));

      // Move ptr to 3, then sparse requests and wrap
      cyc(1'b0, 4'b0100, 1'b1, 4'b0100);
      cyc(1'b0, 4'b0110, 1'b1, 4'b0010);
      cyc(1'b0, 4'b0110, 1'b1, 4'b0100);
      cyc(1'b0, 4'b1000, 1'b1, 4'b1000);
      cyc(1'b0, 4'b1001, 1'b1, 4'b0001);

      // Backpressure: register full, downstream stalled for 3 cycles
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 4'b0001, 1'b0, 4'b0000);
         chk("stall_out_data",  out_data,           held);
         chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      end
      cyc(1'b0, 4'b0001, 1'b1, 4'b0001);
      chk("no_bubble_valid", {31'd0, out_valid}, 32'd1);
      chk("no_bubble_src",   {30'd0, out_src},   32'd0);

      // Drain to empty; ptr stays at 1
      cyc(1'b0, 4'b0000, 1'b1, 4'b0000);
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
      cyc(1'b0, 4'b1111, 1'b1, 4'b0010);

      // Load an entry from requester 2, then reset while it is stalled
      cyc(1'b0, 4'b0110, 1'b1, 4'b0100);
      chk("pre_rst_src", {30'd0, out_src}, 32'd2);
      void'(exp_q.pop_back());
      cyc(1'b1, 4'b1111, 1'b0, 4'b0000);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      cyc(1'b0, 4'b1111, 1'b1, 4'b0001);
      cyc(1'b0, 4'b1111, 1'b1, 4'b0010);
      cyc(1'b0, 4'b0000, 1'b1, 4'b0000);
      cyc(1'b0, 4'b0000, 1'b1, 4'b0000);
      chk("end_out_valid", {31'd0, out_valid}, 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter with a registered output stage. It shares one downstream port, such as a result bus or a write port, among four producers. Each cycle it picks one valid requester by rotating priority and drives the encoded grant as the select of a 4:1 data mux. The selected payload is captured into a one-entry output register with a valid/ready handshake. The block sits between the producers and the shared port, so the port sees one transfer per cycle with no combinational path from producers.

## Interface
- WIDTH, 32, payload width in bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  4  bit i = requester i has a payload
- req_data0..req_data3  in  WIDTH each  requester payloads
- req_ready  out  4  bit i = requester i's payload is taken this cycle; at most one bit set
- out_valid  out  1  output register holds a payload
- out_data  out  WIDTH  registered payload
- out_src  out  2  index of the requester that supplied out_data
- out_ready  in  1  downstream accepts out_data this cycle

## Operation
- State:
  - ptr[1:0]: highest-priority requester.
  - Output register: out_valid, out_data, out_src.
- load = ~rst & (~out_valid | out_ready).
- Winner selection:
  - Winner = the first i with req_valid[i] set, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - any_req = |req_valid.
- Grant: req_ready[i] = load & any_req & (i == winner). It is combinational from req_valid, ptr, out_valid and out_ready. req_ready must not depend on req_data.
- Transfer: a requester transfer occurs when req_valid[i] & req_ready[i]. On transfer:
  - out_data <= req_data[winner]; out_src <= winner; out_valid <= 1.
  - ptr <= winner + 1 (mod 4, wraps 3→0).
- Drain with no refill: if out_valid & out_ready & ~any_req, then out_valid <= 0. out_data and out_src hold their values.
- Stall: if out_valid & ~out_ready, the output register and ptr hold, and req_ready = 0.
- Idle: if load & ~any_req, ptr holds.
- Simultaneous drain and load: the old entry leaves and the new entry enters in the same cycle, with no bubble.
- Fairness: a requester that holds req_valid continuously is granted within 4 transfers.
- Producers must hold req_valid and req_data until they see req_ready. The arbiter does not buffer ungranted payloads.

## Timing
- Reset values on the cycle after rst is sampled high:
  - out_valid = 0, out_data = 0, out_src = 0, ptr = 0.
  - req_ready = 0 while rst is high.
- If rst is asserted mid-operation, a pending out_data is dropped and no grant is issued in that cycle.
- Latency: a transfer in cycle N gives out_valid = 1 with that payload in cycle N+1.
- Throughput: one transfer per cycle while out_ready stays high.
- Combinational paths:
  - out_ready → req_ready exists by design, through load.
  - No combinational path reaches out_valid, out_data or out_src.

## Structure
- Shared package arb_pkg:
  - localparam NUM_REQ = 4.
  - localparam SRC_W = 2.
  - typedef src_idx_t of width SRC_W, used by any later N-way arbiters.
- Sub-modules:
  - A rotating priority picker, rr_pick4. Inputs: req_valid[3:0] and ptr. Outputs: a winner index and any_req. It is purely combinational.
  - The existing mux4 (WIDTH = WIDTH), with s = winner, selects req_data. No other payload muxing is allowed.
- The top level holds only the ptr register, the output register and the load/grant logic.

## Test plan
- Reset:
  - Stimulus: hold rst for 2 cycles with req_valid = 4'b1111.
  - Response: req_ready = 0 throughout. Afterwards out_valid = 0, out_src = 0, out_data = 0, and the first grant goes to requester 0.
- Full contention:
  - Stimulus: req_valid = 4'b1111, out_ready = 1, for 8 cycles.
  - Response: out_src sequence 0,1,2,3,0,1,2,3, one cycle behind req_ready, with out_data equal to the matching req_dataN.
- Sparse requests and pointer wrap:
  - Stimulus: ptr = 3, req_valid = 4'b0110.
  - Response: grant 1, then ptr = 2. The next grant is 2, then ptr = 3.
  - Then with req_valid = 4'b1000: grant 3, then ptr = 0 (wrap).
- Backpressure:
  - Stimulus: out_valid = 1, out_ready = 0 for 3 cycles while req_valid = 4'b0001.
  - Response: req_ready = 0 and out_data stable. On the cycle out_ready = 1, req_ready[0] = 1 and the new payload appears the next cycle with no bubble.
- Drain to empty:
  - Stimulus: out_valid = 1, out_ready = 1, req_valid = 0.
  - Response: out_valid = 0 next cycle and ptr unchanged.
- Mid-operation reset:
  - Stimulus: out_valid = 1 with out_src = 2, then rst pulses for 1 cycle.
  - Response: out_valid = 0 and ptr = 0 next cycle, and the held payload is never presented again.
